regbank_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one register bank of DEPTH words × DW bits between NREQ requesters. Each requester presents an address and data with a request; the block grants one requester at a time, commits its write into the bank, and acknowledges it. The bank contents are readable at any time through a separate read port. The block sits between the requesting datapath units and the flop bank they share.

---
 rtl/regbank_arb_pkg.sv | 22 ++
 rtl/rr_priority_picker.sv | 40 ++++
 rtl/regbank_write_arbiter.sv | 97 +++++++++
 tb/tb_regbank_write_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_arb_pkg.sv
// Shared types and sizing helpers for the register-bank write arbiter.
package regbank_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above ptr wins,
// searching upward with wrap-around.
module rr_priority_picker
    import regbank_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr + i folded back into 0..NREQ-1 without a modulo operator
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter in front of a shared DEPTH x DW flop bank.
// Each transaction runs IDLE -> GRANT (capture) -> COMMIT (write + ack).
module regbank_write_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = addr_width(DEPTH),
    localparam int IW   = idx_width(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output state_t               dbg_state
);

    // Handshake: a requester raises req with stable addr/wdata and holds all
    // three until it sees its ack pulse; gnt marks the transaction in flight,
    // and req still high in the ack cycle is arbitrated as a fresh request.

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [AW-1:0]   stage_addr;
    logic [DW-1:0]   stage_data;
    logic [DW-1:0]   bank [DEPTH];

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    rr_priority_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            ack        <= '0;
            ptr        <= '0;
            win        <= '0;
            stage_addr <= '0;
            stage_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt   <= pick_onehot;
                        win   <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Captured here, so a withdraw after this edge cannot change the write
                    stage_addr <= addr[int'(win)*AW +: AW];
                    stage_data <= wdata[int'(win)*DW +: DW];
                    state      <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    bank[stage_addr] <= stage_data;
                    ack              <= gnt;
                    gnt              <= '0;
                    ptr              <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
                    state            <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign rd_data   = bank[rd_addr];
    assign dbg_state = state;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_regbank_write_arbiter;
    import regbank_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic                 clock;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        rd_data;
    state_t               dbg_state;

    regbank_write_arbiter #(
        .NREQ  (NREQ),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit rand_en    = 1'b0;
    logic [NREQ-1:0] keep_mask = '0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // One transaction at a time: arbitration at edge t, capture at t+1,
    // write and ack at t+2, next arbitration possible at t+3.
    int            m_win = -1;
    int            m_age = 0;
    int            m_ptr = 0;
    logic [NREQ-1:0] m_ack = '0;
    logic [DW-1:0] m_bank [DEPTH];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_win = -1;
            m_age = 0;
            m_ptr = 0;
            m_ack = '0;
            m_addr = '0;
            m_data = '0;
            for (int a = 0; a < DEPTH; a++) m_bank[a] = '0;
        end else begin
            m_ack = '0;
            if (m_win >= 0) begin
                m_age++;
                if (m_age == 1) begin
                    m_addr = addr[m_win*AW +: AW];
                    m_data = wdata[m_win*DW +: DW];
                end else begin
                    m_bank[m_addr] = m_data;
                    m_ack[m_win]   = 1'b1;
                    m_ptr          = (m_win + 1) % NREQ;
                    m_win          = -1;
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (m_win < 0 && req[c]) m_win = c;
                end
                m_age = 0;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    int ack_who[$];
    int ack_cyc[$];
    int waits [NREQ];

    always @(negedge clock) begin
        logic [NREQ-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_win >= 0) exp_gnt[m_win] = 1'b1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("ack", 32'(ack), 32'(m_ack));
        check("busy", 32'(busy), 32'(m_win >= 0));
        check("rd_data", 32'(rd_data), 32'(m_bank[rd_addr]));
        check("gnt_ack_overlap", 32'(gnt & ack), 32'd0);
        for (int j = 0; j < NREQ; j++) begin
            if (ack[j]) begin
                ack_who.push_back(j);
                ack_cyc.push_back(cyc);
            end
        end
        if (ack != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    check("wait_bound", 32'(waits[i] <= NREQ - 1), 32'd1);
                    waits[i] = 0;
                end else if (req[i]) begin
                    waits[i]++;
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Requesters drop req in their ack cycle unless told to hold it.
    always begin
        @(posedge clock);
        #1;
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    if (rand_en && $urandom_range(0, 3) == 0) begin
                        addr[i*AW +: AW]  = AW'($urandom_range(0, DEPTH - 1));
                        wdata[i*DW +: DW] = DW'($urandom_range(0, 255));
                    end else if (!keep_mask[i]) begin
                        req[i] = 1'b0;
                    end
                end else if (rand_en && !req[i] && $urandom_range(0, 3) == 0) begin
                    req[i]            = 1'b1;
                    addr[i*AW +: AW]  = AW'($urandom_range(0, DEPTH - 1));
                    wdata[i*DW +: DW] = DW'($urandom_range(0, 255));
                end
            end
            if (rand_en) rd_addr = AW'($urandom_range(0, DEPTH - 1));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic clear_log();
        ack_who.delete();
        ack_cyc.delete();
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step(2);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic set_req(input int i, input int a, input int d);
        addr[i*AW +: AW]  = AW'(a);
        wdata[i*DW +: DW] = DW'(d);
        req[i]            = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int b;
        b = 0;
        while (ack_who.size() < n && b < budget) begin
            step(1);
            b++;
        end
        check("ack_count", 32'(ack_who.size() >= n), 32'd1);
    endtask

    task automatic read_check(input string name, input int a, input int exp);
        rd_addr = AW'(a);
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int start;
        reset   = 1'b1;
        req     = '0;
        addr    = '0;
        wdata   = '0;
        rd_addr = '0;
        step(1);
        do_reset();
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // single request from requester 2
        set_req(2, 3, 8'hA5);
        step(1);
        check("single_gnt_c1", 32'(gnt), 32'b0100);
        check("single_busy_c1", 32'(busy), 32'd1);
        step(1);
        check("single_gnt_c2", 32'(gnt), 32'b0100);
        check("single_ack_c2", 32'(ack), 32'd0);
        step(1);
        check("single_ack_c3", 32'(ack), 32'b0100);
        check("single_gnt_c3", 32'(gnt), 32'd0);
        step(1);
        check("single_idle_after", 32'(busy), 32'd0);
        read_check("single_rd3", 3, 8'hA5);
        for (int a = 0; a < DEPTH; a++) begin
            if (a != 3) read_check("single_rd_other", a, 0);
        end

        // fairness with all requesters held high from ptr=0
        do_reset();
        keep_mask = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, i, 8'h10 + i);
        start = cyc;
        wait_acks(5, 40);
        keep_mask = '0;
        req = '0;
        if (ack_who.size() >= 5) begin
            check("fair_first_lat", 32'(ack_cyc[0] - start), 32'd3);
            check("fair_order0", 32'(ack_who[0]), 32'd0);
            check("fair_order1", 32'(ack_who[1]), 32'd1);
            check("fair_order2", 32'(ack_who[2]), 32'd2);
            check("fair_order3", 32'(ack_who[3]), 32'd3);
            check("fair_order4", 32'(ack_who[4]), 32'd0);
            for (int k = 0; k < 4; k++) begin
                check("fair_spacing", 32'(ack_cyc[k+1] - ack_cyc[k]), 32'd3);
            end
        end
        step(6);
        read_check("fair_rd2", 2, 8'h12);

        // pointer wrap: serve 3, then 0 and 3 together
        clear_log();
        set_req(3, 4, 8'h33);
        wait_acks(1, 10);
        step(1);
        clear_log();
        set_req(0, 1, 8'h40);
        set_req(3, 2, 8'h43);
        wait_acks(2, 20);
        if (ack_who.size() >= 2) begin
            check("wrap_first", 32'(ack_who[0]), 32'd0);
            check("wrap_second", 32'(ack_who[1]), 32'd3);
        end
        step(2);

        // early withdraw by requester 0 during GRANT (ptr now 0)
        clear_log();
        set_req(0, 6, 8'h3C);
        step(1);
        check("withdraw_gnt", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        wait_acks(1, 10);
        if (ack_who.size() >= 1) check("withdraw_ack", 32'(ack_who[0]), 32'd0);
        step(1);
        read_check("withdraw_rd6", 6, 8'h3C);

        // same-address contention with ptr=1
        clear_log();
        set_req(1, 5, 8'h11);
        set_req(2, 5, 8'h22);
        wait_acks(2, 20);
        if (ack_who.size() >= 2) begin
            check("contend_first", 32'(ack_who[0]), 32'd1);
            check("contend_second", 32'(ack_who[1]), 32'd2);
        end
        step(1);
        read_check("contend_rd5", 5, 8'h22);

        // reset during GRANT aborts the write
        clear_log();
        set_req(3, 7, 8'hFF);
        step(1);
        check("abort_gnt_before", 32'(gnt), 32'b1000);
        reset = 1'b1;
        req   = '0;
        #1;
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        step(2);
        reset = 1'b0;
        step(5);
        check("abort_no_ack", 32'(ack_who.size()), 32'd0);
        check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
        read_check("abort_rd7", 7, 0);

        // random traffic against the model
        do_reset();
        rand_en = 1'b1;
        step(600);
        rand_en = 1'b0;
        for (int b = 0; b < 100 && (req != '0 || busy); b++) step(1);
        check("drain", 32'({req, busy}), 32'd0);
        for (int a = 0; a < DEPTH; a++) read_check("final_rd", a, int'(m_bank[a]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
